// File: rtl/fpa_pkg.sv
// fpa_pkg -- shared definitions for the floating-point adder/multiplier
// result paths.
//   EXP_W, FRAC_W : IEEE-754 single-precision exponent / fraction widths
//   EXP_ONES      : all-ones exponent (Inf / NaN encoding)
//   fp_word_t     : result word split into sign / exponent / fraction
package fpa_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;

endpackage

// File: rtl/fpa_result_buffer_if.sv
// fpa_result_buffer_if -- groups the adder-side, consumer-side and status
// signals of the result buffer.
//   master : upstream/consumer/software side (drives Issue, Value_Out,
//            Result, Out_Ready, Flag_Clr)
//   slave  : the result buffer (drives Out_Valid, Out_Data, Count,
//            Can_Issue, the sticky flags and Overflow)
interface fpa_result_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             Issue;
  logic             Value_Out;
  logic [WIDTH-1:0] Result;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic [CW-1:0]    Count;
  logic             Can_Issue;
  logic             Flag_Clr;
  logic             Flag_NaN;
  logic             Flag_Inf;
  logic             Flag_Zero;
  logic             Overflow;

  modport master (
    output Issue, Value_Out, Result, Out_Ready, Flag_Clr,
    input  Out_Valid, Out_Data, Count, Can_Issue,
           Flag_NaN, Flag_Inf, Flag_Zero, Overflow
  );

  modport slave (
    input  Issue, Value_Out, Result, Out_Ready, Flag_Clr,
    output Out_Valid, Out_Data, Count, Can_Issue,
           Flag_NaN, Flag_Inf, Flag_Zero, Overflow
  );

endinterface

// File: rtl/fpa_result_class.sv
// fpa_result_class -- combinational IEEE-754 single classifier.
//   value   : result word
//   is_nan  : exponent all ones, fraction non-zero
//   is_inf  : exponent all ones, fraction zero
//   is_zero : exponent and fraction zero (either sign)
// Denormals raise none of the outputs.
module fpa_result_class
  import fpa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero
);

  fp_word_t w;
  logic     exp_ones;
  logic     exp_zero;
  logic     frac_zero;
  logic     unused_sign;

  assign w           = fp_word_t'(value[$bits(fp_word_t)-1:0]);
  assign unused_sign = w.sign;  // class does not depend on sign

  assign exp_ones  = (w.exp == EXP_ONES);
  assign exp_zero  = (w.exp == '0);
  assign frac_zero = (w.frac == '0);

  assign is_nan  = exp_ones & ~frac_zero;
  assign is_inf  = exp_ones &  frac_zero;
  assign is_zero = exp_zero &  frac_zero;

endmodule

// File: rtl/fpa_result_buffer.sv
// fpa_result_buffer -- collector behind the pipelined FP adder.
//   Clk   : clock, rising edge
//   Clear : asynchronous active-low reset
//   bus   : slave side of fpa_result_buffer_if
//           Issue/Value_Out/Result from the adder, Out_* handshake to the
//           consumer, Count occupancy, Can_Issue credit, sticky
//           NaN/Inf/Zero flags and Overflow, cleared by Flag_Clr.
// The adder cannot be stalled, so Can_Issue counts FIFO words plus
// operations in flight; upstream launching only while it is high can never
// overrun the FIFO regardless of adder latency.
module fpa_result_buffer
  import fpa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic               Clk,
  input logic               Clear,
  fpa_result_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic             flag_nan_q, flag_nan_d;
  logic             flag_inf_q, flag_inf_d;
  logic             flag_zero_q, flag_zero_d;
  logic             overflow_q, overflow_d;

  logic             push, pop, full;
  logic             is_nan, is_inf, is_zero;
  logic [CW:0]      credit_used;

  fpa_result_class #(.WIDTH(WIDTH)) u_class (
    .value   (bus.Result),
    .is_nan  (is_nan),
    .is_inf  (is_inf),
    .is_zero (is_zero)
  );

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    pop  = (count_q != '0) & bus.Out_Ready;
    full = (count_q == DEPTH_C);
    // A full FIFO still accepts a word when the head leaves the same cycle.
    push = bus.Value_Out & (~full | pop);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Saturate at both ends: late results after a reset must not wrap the
    // counter below zero, and a protocol-violating Issue must not wrap it up.
    inflight_d = inflight_q;
    case ({bus.Issue, bus.Value_Out})
      2'b10:   if (inflight_q != DEPTH_C) inflight_d = inflight_q + CW'(1);
      2'b01:   if (inflight_q != '0)      inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Set has priority over Flag_Clr.
    flag_nan_d  = (flag_nan_q  & ~bus.Flag_Clr) | (bus.Value_Out & is_nan);
    flag_inf_d  = (flag_inf_q  & ~bus.Flag_Clr) | (bus.Value_Out & is_inf);
    flag_zero_d = (flag_zero_q & ~bus.Flag_Clr) | (bus.Value_Out & is_zero);
    overflow_d  = (overflow_q  & ~bus.Flag_Clr) | (bus.Value_Out & ~push);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge Clk or negedge Clear) begin
    if (!Clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      flag_nan_q  <= 1'b0;
      flag_inf_q  <= 1'b0;
      flag_zero_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      flag_nan_q  <= flag_nan_d;
      flag_inf_q  <= flag_inf_d;
      flag_zero_q <= flag_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; Count gates Out_Valid, so stale
  // words are never presented, and leaving it out keeps it a plain RAM.
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.Result;
  end

  // One extra bit so Count + Inflight (up to 2*DEPTH) cannot wrap.
  assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};

  assign bus.Out_Data  = mem_q[rd_ptr_q];
  assign bus.Out_Valid = (count_q != '0);
  assign bus.Count     = count_q;
  assign bus.Can_Issue = (credit_used < {1'b0, DEPTH_C});
  assign bus.Flag_NaN  = flag_nan_q;
  assign bus.Flag_Inf  = flag_inf_q;
  assign bus.Flag_Zero = flag_zero_q;
  assign bus.Overflow  = overflow_q;

endmodule

// File: tb/tb_fpa_result_buffer.sv
// tb_fpa_result_buffer -- directed bench for fpa_result_buffer.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, so every check sees settled post-edge register state.
module tb_fpa_result_buffer;

  logic clk;
  logic clear;
  int   n_cmp;
  int   n_bad;

  fpa_result_buffer_if #(.WIDTH(32), .DEPTH(4)) bus ();

  fpa_result_buffer #(.DEPTH(4), .WIDTH(32)) dut (
    .Clk   (clk),
    .Clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Issue     = 1'b0;
    bus.Value_Out = 1'b0;
    bus.Result    = 32'h0;
    bus.Out_Ready = 1'b0;
    bus.Flag_Clr  = 1'b0;
  endtask

  task automatic test_power_on();
    n_cmp++; if (bus.Out_Valid !== 1'b0) begin n_bad++; $display("FAIL por_valid: got %b want 0", bus.Out_Valid); end
    n_cmp++; if (bus.Count !== 3'd0) begin n_bad++; $display("FAIL por_count: got %0d want 0", bus.Count); end
    n_cmp++; if (bus.Can_Issue !== 1'b1) begin n_bad++; $display("FAIL por_can_issue: got %b want 1", bus.Can_Issue); end
    n_cmp++; if ({bus.Flag_NaN, bus.Flag_Inf, bus.Flag_Zero, bus.Overflow} !== 4'b0000) begin
      n_bad++; $display("FAIL por_flags: got %b want 0000", {bus.Flag_NaN, bus.Flag_Inf, bus.Flag_Zero, bus.Overflow}); end
  endtask

  task automatic test_credit();
    logic [31:0] vals [4];
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    bus.Out_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Issue = 1'b1;
      step();
      n_cmp++; if (bus.Can_Issue !== (i < 3)) begin n_bad++; $display("FAIL credit_issue%0d: got %b want %b", i, bus.Can_Issue, (i < 3)); end
    end
    bus.Issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Value_Out = 1'b1;
      bus.Result    = vals[i];
      step();
    end
    bus.Value_Out = 1'b0;
    n_cmp++; if (bus.Count !== 3'd4) begin n_bad++; $display("FAIL credit_count: got %0d want 4", bus.Count); end
    n_cmp++; if (bus.Can_Issue !== 1'b0) begin n_bad++; $display("FAIL credit_full: got %b want 0", bus.Can_Issue); end
    n_cmp++; if (bus.Overflow !== 1'b0) begin n_bad++; $display("FAIL credit_ovf: got %b want 0", bus.Overflow); end
    bus.Out_Ready = 1'b1;
    step();
    bus.Out_Ready = 1'b0;
    n_cmp++; if (bus.Can_Issue !== 1'b1) begin n_bad++; $display("FAIL credit_after_pop: got %b want 1", bus.Can_Issue); end
    n_cmp++; if (bus.Count !== 3'd3) begin n_bad++; $display("FAIL credit_count_pop: got %0d want 3", bus.Count); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (bus.Out_Data !== vals[i]) begin n_bad++; $display("FAIL credit_data%0d: got %h want %h", i, bus.Out_Data, vals[i]); end
      bus.Out_Ready = 1'b1;
      step();
    end
    bus.Out_Ready = 1'b0;
    n_cmp++; if (bus.Out_Valid !== 1'b0) begin n_bad++; $display("FAIL credit_drained: got %b want 0", bus.Out_Valid); end
  endtask

  task automatic test_order_wrap();
    logic [31:0] exp_q [$];
    int          mcount;
    int          pushed;
    logic        ready;
    logic        pop_m;
    logic        push_m;
    mcount = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pushed == 10 && mcount == 0) break;
      ready  = (cyc % 2 == 0);
      pop_m  = ready && (mcount > 0);
      push_m = (pushed < 10) && (mcount < 4 || pop_m);
      if (pop_m) begin
        n_cmp++; if (bus.Out_Data !== exp_q[0]) begin n_bad++; $display("FAIL order_data: got %h want %h", bus.Out_Data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      bus.Out_Ready = ready;
      bus.Value_Out = push_m;
      bus.Result    = 32'h4100_0000 + 32'(pushed);
      if (push_m) begin
        exp_q.push_back(32'h4100_0000 + 32'(pushed));
        pushed++;
      end
      step();
      mcount = mcount + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
    idle_inputs();
    n_cmp++; if (bus.Count !== 3'd0) begin n_bad++; $display("FAIL order_count: got %0d want 0", bus.Count); end
    n_cmp++; if (bus.Overflow !== 1'b0) begin n_bad++; $display("FAIL order_ovf: got %b want 0", bus.Overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] fill [4];
    logic [31:0] drain [4];
    fill  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    drain = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h41000000};
    bus.Out_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Value_Out = 1'b1;
      bus.Result    = fill[i];
      step();
    end
    n_cmp++; if (bus.Count !== 3'd4) begin n_bad++; $display("FAIL full_fill: got %0d want 4", bus.Count); end
    bus.Result    = 32'h41000000;
    bus.Out_Ready = 1'b1;
    step();
    n_cmp++; if (bus.Count !== 3'd4) begin n_bad++; $display("FAIL full_pushpop_count: got %0d want 4", bus.Count); end
    n_cmp++; if (bus.Overflow !== 1'b0) begin n_bad++; $display("FAIL full_pushpop_ovf: got %b want 0", bus.Overflow); end
    bus.Out_Ready = 1'b0;
    bus.Result    = 32'hDEADBEEF;
    step();
    bus.Value_Out = 1'b0;
    n_cmp++; if (bus.Overflow !== 1'b1) begin n_bad++; $display("FAIL full_drop_ovf: got %b want 1", bus.Overflow); end
    n_cmp++; if (bus.Count !== 3'd4) begin n_bad++; $display("FAIL full_drop_count: got %0d want 4", bus.Count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.Out_Data !== drain[i]) begin n_bad++; $display("FAIL full_drain%0d: got %h want %h", i, bus.Out_Data, drain[i]); end
      bus.Out_Ready = 1'b1;
      step();
    end
    bus.Out_Ready = 1'b0;
    n_cmp++; if (bus.Out_Valid !== 1'b0) begin n_bad++; $display("FAIL full_empty: got %b want 0", bus.Out_Valid); end
  endtask

  typedef struct {
    logic        pre_clr;
    logic        clr_same;
    logic [31:0] value;
    logic [2:0]  flags;  // {nan, inf, zero}
  } flag_vec_t;

  task automatic test_flags();
    flag_vec_t tbl [7];
    tbl[0] = '{1'b1, 1'b0, 32'h7FC00000, 3'b100};
    tbl[1] = '{1'b1, 1'b0, 32'hFF800000, 3'b010};
    tbl[2] = '{1'b1, 1'b0, 32'h80000000, 3'b001};
    tbl[3] = '{1'b1, 1'b0, 32'h00000001, 3'b000};
    tbl[4] = '{1'b1, 1'b0, 32'h7FC00000, 3'b100};
    tbl[5] = '{1'b0, 1'b0, 32'h00000000, 3'b101};
    tbl[6] = '{1'b0, 1'b1, 32'h7F800000, 3'b010};
    bus.Out_Ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].pre_clr) begin
        bus.Flag_Clr = 1'b1;
        step();
        bus.Flag_Clr = 1'b0;
      end
      bus.Value_Out = 1'b1;
      bus.Result    = tbl[i].value;
      bus.Flag_Clr  = tbl[i].clr_same;
      step();
      bus.Value_Out = 1'b0;
      bus.Flag_Clr  = 1'b0;
      n_cmp++; if ({bus.Flag_NaN, bus.Flag_Inf, bus.Flag_Zero} !== tbl[i].flags) begin
        n_bad++; $display("FAIL flags_%0d (%h): got %b want %b", i, tbl[i].value, {bus.Flag_NaN, bus.Flag_Inf, bus.Flag_Zero}, tbl[i].flags); end
      n_cmp++; if (bus.Overflow !== 1'b0) begin n_bad++; $display("FAIL flags_ovf_%0d: got %b want 0", i, bus.Overflow); end
    end
    step();
    bus.Out_Ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.Out_Ready = 1'b0;
    bus.Issue     = 1'b1;
    step();
    bus.Value_Out = 1'b1;
    bus.Result    = 32'h7FC00000;
    step();
    bus.Issue  = 1'b0;
    bus.Result = 32'h00000000;
    step();
    bus.Value_Out = 1'b0;
    n_cmp++; if (bus.Count !== 3'd2) begin n_bad++; $display("FAIL rst_pre_count: got %0d want 2", bus.Count); end
    n_cmp++; if (bus.Flag_NaN !== 1'b1) begin n_bad++; $display("FAIL rst_pre_nan: got %b want 1", bus.Flag_NaN); end
    #2 clear = 1'b0;
    #1;
    n_cmp++; if (bus.Out_Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.Out_Valid); end
    n_cmp++; if (bus.Count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.Count); end
    n_cmp++; if (bus.Can_Issue !== 1'b1) begin n_bad++; $display("FAIL rst_can_issue: got %b want 1", bus.Can_Issue); end
    n_cmp++; if ({bus.Flag_NaN, bus.Flag_Inf, bus.Flag_Zero, bus.Overflow} !== 4'b0000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 0000", {bus.Flag_NaN, bus.Flag_Inf, bus.Flag_Zero, bus.Overflow}); end
    #2 clear = 1'b1;
    step();
    bus.Value_Out = 1'b1;
    bus.Result    = 32'h12345678;
    step();
    bus.Value_Out = 1'b0;
    n_cmp++; if (bus.Count !== 3'd1) begin n_bad++; $display("FAIL rst_after_count: got %0d want 1", bus.Count); end
    n_cmp++; if (bus.Out_Data !== 32'h12345678) begin n_bad++; $display("FAIL rst_after_data: got %h want 12345678", bus.Out_Data); end
    n_cmp++; if (bus.Can_Issue !== 1'b1) begin n_bad++; $display("FAIL rst_after_credit: got %b want 1", bus.Can_Issue); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    clear = 1'b0;
    #3;
    test_power_on();
    #9 clear = 1'b1;
    test_credit();
    test_order_wrap();
    test_full_push_pop();
    test_flags();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
